// File: rtl/wall_datapath.sv
// Wall datapath: x position, gap row, movement tick, collision and score.
// Optional WALL_SPEEDUP_EN: step grows by 1 px per 8 walls passed, capped at 4.
module wall_datapath #(
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int WALL_W    = 4,
    parameter int GAP_H     = 32,
    parameter int FRAME_DIV = 833333,
    parameter int STEP      = 1,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           move,
    input  logic [X_W-1:0] player_x,
    input  logic [Y_W-1:0] player_y,
    output logic [X_W-1:0] wall_x,
    output logic [Y_W-1:0] gap_y,
    output logic           touched,
    output logic           hit,
    output logic [7:0]     score
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [X_W-1:0]   X_START = X_W'(SCREEN_W - WALL_W);
    localparam logic [6:0]       GMAX    = 7'(SCREEN_H - GAP_H);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FRAME_DIV - 1);

    logic [7:0]       lfsr;
    logic [CNT_W-1:0] cnt;
    logic             lfsr_fb;
    logic             tick;
    logic             collide;
    logic [6:0]       gap_v;
    logic [6:0]       gap_next;
    logic [X_W:0]     px_ext, wx_lo, wx_hi;
    logic [Y_W:0]     py_ext, gy_lo, gy_hi;
    logic [X_W-1:0]   step_eff;

    // x^8+x^6+x^5+x^4+1, shifting left; the all-zero state is unreachable from A5
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Fold values above GMAX back into range so every gap fits on screen
    assign gap_v    = lfsr[6:0];
    assign gap_next = (gap_v > GMAX) ? (gap_v - GMAX - 7'd1) : gap_v;

    assign tick = move && !start && (cnt == CNT_TOP);

    // Widened compares so the right/bottom edges cannot wrap
    assign px_ext  = {1'b0, player_x};
    assign wx_lo   = {1'b0, wall_x};
    assign wx_hi   = wx_lo + (X_W+1)'(WALL_W - 1);
    assign py_ext  = {1'b0, player_y};
    assign gy_lo   = {1'b0, gap_y};
    assign gy_hi   = gy_lo + (Y_W+1)'(GAP_H - 1);
    assign collide = (px_ext >= wx_lo) && (px_ext <= wx_hi) &&
                     ((py_ext < gy_lo) || (py_ext > gy_hi));

`ifdef WALL_SPEEDUP_EN
    logic [5:0] step_sum;
    assign step_sum = 6'(STEP) + {1'b0, score[7:3]};
    assign step_eff = (step_sum > 6'd4) ? X_W'(4) : X_W'(step_sum);
`else
    assign step_eff = X_W'(STEP);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wall_x  <= X_START;
            gap_y   <= '0;
            touched <= 1'b0;
            hit     <= 1'b0;
            score   <= 8'd0;
            cnt     <= '0;
            lfsr    <= 8'hA5;
        end else begin
            lfsr    <= {lfsr[6:0], lfsr_fb};
            touched <= 1'b0;
            if (start) begin
                wall_x <= X_START;
                gap_y  <= Y_W'(gap_next);
                hit    <= 1'b0;
                cnt    <= '0;
            end else if (!move) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= '0;
                if (collide) begin
                    hit     <= 1'b1;
                    touched <= 1'b1;
                end else if (wall_x <= step_eff) begin
                    wall_x  <= '0;
                    touched <= 1'b1;
                    if (score != 8'hFF)
                        score <= score + 8'd1;
                end else begin
                    wall_x <= wall_x - step_eff;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
